// File: rtl/alu_share_arbiter.sv
// Round-robin sequencer that time-shares one combinational ALU among NUM_REQ
// requesters, returning each result into a per-requester response slot.
module alu_share_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned XLEN    = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [3*NUM_REQ-1:0]    req_alu_control,
  input  logic [XLEN*NUM_REQ-1:0] req_a,
  input  logic [XLEN*NUM_REQ-1:0] req_b,
  output logic [NUM_REQ-1:0]      resp_valid,
  input  logic [NUM_REQ-1:0]      resp_ready,
  output logic [XLEN*NUM_REQ-1:0] resp_result,
  output logic [NUM_REQ-1:0]      resp_zero,
  output logic [2:0]              alu_control_o,
  output logic [XLEN-1:0]         alu_a_o,
  output logic [XLEN-1:0]         alu_b_o,
  input  logic [XLEN-1:0]         alu_result_i,
  output logic                    busy
);

  localparam int unsigned IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CTRL_W = 3;

  typedef enum logic {
    IDLE = 1'b0,
    EXEC = 1'b1
  } state_e;

  typedef struct packed {
    logic [CTRL_W-1:0] op;
    logic [XLEN-1:0]   a;
    logic [XLEN-1:0]   b;
  } alu_req_t;

  state_e                   state_q, state_d;
  logic [IDX_W-1:0]         rr_ptr_q;
  logic [IDX_W-1:0]         gnt_q;
  alu_req_t                 req_q;
  logic [NUM_REQ-1:0]       resp_valid_q;
  logic [XLEN*NUM_REQ-1:0]  resp_result_q;
  logic [NUM_REQ-1:0]       resp_zero_q;

  logic [NUM_REQ-1:0]       eligible_c;
  logic                     grant_found_c;
  logic [IDX_W-1:0]         grant_idx_c;
  logic [IDX_W-1:0]         cand_c;
  alu_req_t                 req_sel_c;
  logic                     cap_en_c;
  logic                     done_en_c;

  // Only the registered slot state gates eligibility; a same-cycle consume does not.
  assign eligible_c = req_valid & ~resp_valid_q;

  // Rotating priority scan starting at rr_ptr.
  always_comb begin
    grant_found_c = 1'b0;
    grant_idx_c   = '0;
    cand_c        = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand_c = IDX_W'((32'(rr_ptr_q) + k) % NUM_REQ);
      if (!grant_found_c && eligible_c[cand_c]) begin
        grant_found_c = 1'b1;
        grant_idx_c   = cand_c;
      end
    end
  end

  always_comb begin
    req_sel_c.op = req_alu_control[32'(grant_idx_c)*CTRL_W +: CTRL_W];
    req_sel_c.a  = req_a[32'(grant_idx_c)*XLEN +: XLEN];
    req_sel_c.b  = req_b[32'(grant_idx_c)*XLEN +: XLEN];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, grant handshake and datapath enables.
  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    cap_en_c  = 1'b0;
    done_en_c = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (grant_found_c) begin
          req_ready[grant_idx_c] = rst_n;
          cap_en_c               = 1'b1;
          state_d                = EXEC;
        end
      end
      EXEC: begin
        done_en_c = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q <= '0;
      gnt_q <= '0;
    end else if (cap_en_c) begin
      req_q <= req_sel_c;
      gnt_q <= grant_idx_c;
    end
  end

  // Response slots: consume clears valid, completion fills the granted slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q      <= '0;
      resp_valid_q  <= '0;
      resp_result_q <= '0;
      resp_zero_q   <= '0;
    end else begin
      resp_valid_q <= resp_valid_q & ~resp_ready;
      if (done_en_c) begin
        resp_valid_q[gnt_q]                         <= 1'b1;
        resp_result_q[32'(gnt_q)*XLEN +: XLEN]      <= alu_result_i;
        resp_zero_q[gnt_q]                          <= (alu_result_i == '0);
        rr_ptr_q <= IDX_W'((32'(gnt_q) + 32'd1) % NUM_REQ);
      end
    end
  end

  assign busy          = (state_q == EXEC);
  assign alu_control_o = busy ? req_q.op : '0;
  assign alu_a_o       = busy ? req_q.a  : '0;
  assign alu_b_o       = busy ? req_q.b  : '0;
  assign resp_valid    = resp_valid_q;
  assign resp_result   = resp_result_q;
  assign resp_zero     = resp_zero_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter: a 2-requester and a 3-requester
// instance, each paired with a behavioural shared ALU.
module tb_alu_share_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  function automatic logic [31:0] alu_f(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    case (op)
      3'b001:  return a - b;
      3'b010:  return a & b;
      3'b011:  return a | b;
      3'b100:  return a ^ b;
      3'b101:  return a >> b[4:0];
      3'b110:  return a << b[4:0];
      default: return a + b;
    endcase
  endfunction

  // NUM_REQ = 2 instance
  logic [1:0]  r2_valid, r2_ready, s2_valid, s2_ready, s2_zero;
  logic [5:0]  r2_ctl;
  logic [63:0] r2_a, r2_b, s2_result;
  logic [2:0]  a2_ctl;
  logic [31:0] a2_a, a2_b, a2_res;
  logic        busy2;
  assign a2_res = alu_f(a2_ctl, a2_a, a2_b);

  alu_share_arbiter #(.NUM_REQ(2), .XLEN(32)) u_dut2 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(r2_valid), .req_ready(r2_ready), .req_alu_control(r2_ctl),
    .req_a(r2_a), .req_b(r2_b),
    .resp_valid(s2_valid), .resp_ready(s2_ready), .resp_result(s2_result),
    .resp_zero(s2_zero),
    .alu_control_o(a2_ctl), .alu_a_o(a2_a), .alu_b_o(a2_b), .alu_result_i(a2_res),
    .busy(busy2)
  );

  // NUM_REQ = 3 instance
  logic [2:0]  r3_valid, r3_ready, s3_valid, s3_ready, s3_zero;
  logic [8:0]  r3_ctl;
  logic [95:0] r3_a, r3_b, s3_result;
  logic [2:0]  a3_ctl;
  logic [31:0] a3_a, a3_b, a3_res;
  logic        busy3;
  assign a3_res = alu_f(a3_ctl, a3_a, a3_b);

  alu_share_arbiter #(.NUM_REQ(3), .XLEN(32)) u_dut3 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(r3_valid), .req_ready(r3_ready), .req_alu_control(r3_ctl),
    .req_a(r3_a), .req_b(r3_b),
    .resp_valid(s3_valid), .resp_ready(s3_ready), .resp_result(s3_result),
    .resp_zero(s3_zero),
    .alu_control_o(a3_ctl), .alu_a_o(a3_a), .alu_b_o(a3_b), .alu_result_i(a3_res),
    .busy(busy3)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  logic [1:0] exp_rr [8];

  initial begin
    r2_valid = '0; r2_ctl = '0; r2_a = '0; r2_b = '0; s2_ready = '0;
    r3_valid = '0; r3_ctl = '0; r3_a = '0; r3_b = '0; s3_ready = '0;
    exp_rr = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00};

    repeat (2) @(posedge clk);
    #1;
    check("rst_resp_valid", 64'(s2_valid), 64'h0);
    check("rst_busy", 64'(busy2), 64'h0);
    check("rst_alu_ctl", 64'(a2_ctl), 64'h0);
    check("rst_result", s2_result, 64'h0);
    #2 rst_n = 1'b1;
    step();

    // Single ADD 5 + 7 on requester 0
    r2_ctl[2:0] = 3'b000; r2_a[31:0] = 32'd5; r2_b[31:0] = 32'd7; r2_valid = 2'b01;
    #1;
    check("add_ready", 64'(r2_ready), 64'h1);
    check("add_busy_idle", 64'(busy2), 64'h0);
    step();
    check("add_busy_exec", 64'(busy2), 64'h1);
    check("add_alu_a", 64'(a2_a), 64'd5);
    check("add_alu_b", 64'(a2_b), 64'd7);
    check("add_alu_ctl", 64'(a2_ctl), 64'h0);
    check("add_ready_exec", 64'(r2_ready), 64'h0);
    r2_valid = 2'b00;
    step();
    check("add_resp_valid", 64'(s2_valid), 64'h1);
    check("add_result", 64'(s2_result[31:0]), 64'd12);
    check("add_zero", 64'(s2_zero[0]), 64'h0);
    step();
    check("add_hold", 64'(s2_valid), 64'h1);
    s2_ready = 2'b01;
    step();
    s2_ready = 2'b00;
    check("add_cleared", 64'(s2_valid), 64'h0);
    check("add_result_kept", 64'(s2_result[31:0]), 64'd12);

    // SUB producing zero on requester 1
    r2_ctl[5:3] = 3'b001; r2_a[63:32] = 32'h1234; r2_b[63:32] = 32'h1234; r2_valid = 2'b10;
    #1;
    check("sub_ready", 64'(r2_ready), 64'h2);
    step();
    r2_valid = 2'b00;
    step();
    check("sub_resp_valid", 64'(s2_valid), 64'h2);
    check("sub_result", 64'(s2_result[63:32]), 64'h0);
    check("sub_zero", 64'(s2_zero), 64'h2);
    s2_ready = 2'b10;
    step();
    s2_ready = 2'b00;

    // Round-robin with both requesters always valid and always consuming
    do_reset();
    r2_ctl = {3'b011, 3'b000};
    r2_a   = {32'h0000_00F0, 32'd1};
    r2_b   = {32'h0000_000F, 32'd2};
    s2_ready = 2'b11;
    r2_valid = 2'b11;
    for (int i = 0; i < 8; i++) begin
      #1;
      check($sformatf("rr_grant_%0d", i), 64'(r2_ready), 64'(exp_rr[i]));
      step();
    end
    r2_valid = 2'b00;
    #1;
    check("rr_result0", 64'(s2_result[31:0]), 64'd3);
    check("rr_result1", 64'(s2_result[63:32]), 64'h0000_00FF);
    step();
    step();
    check("rr_drained", 64'(s2_valid), 64'h0);
    s2_ready = 2'b00;

    // Slot back-pressure on requester 0
    do_reset();
    r2_ctl = {3'b100, 3'b000};
    r2_a   = {32'h0000_00FF, 32'd10};
    r2_b   = {32'h0000_000F, 32'd20};
    r2_valid = 2'b01;
    #1;
    check("bp_grant0", 64'(r2_ready), 64'h1);
    step();
    check("bp_exec0", 64'(r2_ready), 64'h0);
    step();
    r2_valid = 2'b11;
    #1;
    check("bp_slot0_full", 64'(s2_valid), 64'h1);
    check("bp_serve1", 64'(r2_ready), 64'h2);
    step();
    r2_valid = 2'b01;
    #1;
    check("bp_exec1", 64'(r2_ready), 64'h0);
    step();
    check("bp_blocked", 64'(r2_ready), 64'h0);
    check("bp_both_full", 64'(s2_valid), 64'h3);
    step();
    s2_ready = 2'b01;
    #1;
    check("bp_same_cycle_free", 64'(r2_ready), 64'h0);
    step();
    s2_ready = 2'b00;
    #1;
    check("bp_regrant0", 64'(r2_ready), 64'h1);
    check("bp_result0", 64'(s2_result[31:0]), 64'd30);
    check("bp_result1", 64'(s2_result[63:32]), 64'h0000_00F0);
    step();
    r2_valid = 2'b00;
    step();
    s2_ready = 2'b11;
    step();
    s2_ready = 2'b00;

    // Wrap with three requesters
    do_reset();
    r3_ctl[8:6] = 3'b110; r3_a[95:64] = 32'd1; r3_b[95:64] = 32'd31; r3_valid = 3'b100;
    #1;
    check("w3_grant2", 64'(r3_ready), 64'h4);
    step();
    r3_valid = 3'b000;
    step();
    check("w3_resp2", 64'(s3_valid), 64'h4);
    check("w3_sll", 64'(s3_result[95:64]), 64'h8000_0000);
    check("w3_zero", 64'(s3_zero), 64'h0);
    s3_ready = 3'b100;
    step();
    s3_ready = 3'b000;
    r3_ctl[2:0] = 3'b000; r3_a[31:0] = 32'd3; r3_b[31:0] = 32'd4; r3_valid = 3'b101;
    #1;
    check("w3_wrap_to0", 64'(r3_ready), 64'h1);
    step();
    r3_valid = 3'b000;
    step();
    check("w3_result0", 64'(s3_result[31:0]), 64'd7);
    s3_ready = 3'b001;
    step();
    s3_ready = 3'b000;
    r3_valid = 3'b101;
    #1;
    check("w3_next_is2", 64'(r3_ready), 64'h4);
    step();
    r3_valid = 3'b000;
    step();
    s3_ready = 3'b111;
    step();
    s3_ready = 3'b000;

    // Asynchronous reset during EXEC of an AND
    do_reset();
    r2_ctl[2:0] = 3'b010; r2_a[31:0] = 32'h0000_FF00; r2_b[31:0] = 32'h0000_0FF0;
    r2_valid = 2'b01;
    #1;
    check("ar_grant", 64'(r2_ready), 64'h1);
    step();
    check("ar_busy", 64'(busy2), 64'h1);
    check("ar_alu_ctl", 64'(a2_ctl), 64'h2);
    #2 rst_n = 1'b0;
    #1;
    check("ar_busy_rst", 64'(busy2), 64'h0);
    check("ar_ctl_rst", 64'(a2_ctl), 64'h0);
    check("ar_a_rst", 64'(a2_a), 64'h0);
    check("ar_b_rst", 64'(a2_b), 64'h0);
    check("ar_ready_rst", 64'(r2_ready), 64'h0);
    check("ar_valid_rst", 64'(s2_valid), 64'h0);
    r2_valid = 2'b00;
    @(posedge clk);
    #2 rst_n = 1'b1;
    step();
    step();
    step();
    check("ar_no_resp", 64'(s2_valid), 64'h0);
    check("ar_no_result", s2_result, 64'h0);
    r2_ctl = '0;
    r2_valid = 2'b11;
    #1;
    check("ar_first_grant0", 64'(r2_ready), 64'h1);
    step();
    r2_valid = 2'b00;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
